// File: rtl/spi_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_feeder
// Purpose  : Byte FIFO that feeds a downstream SPI master one byte at a time,
//            pacing requests off the master's slave-select with an idle gap.
// Options  : SPI_FEEDER_TIMEOUT_EN adds a 1024-cycle abort on the WAIT states
//            and the timeout output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_feeder #(
   parameter int DEPTH    = 8,
   parameter int GAP_CLKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic [4:0] level,
   output logic       spi_start,
   output logic [7:0] spi_data,
   input  logic       spi_ss,
`ifdef SPI_FEEDER_TIMEOUT_EN
   output logic       timeout,
`endif
   output logic       busy,
   output logic       overflow
);

   localparam int         c_AW       = $clog2(DEPTH);
   localparam logic [4:0] c_DEPTH    = 5'(DEPTH);
   localparam logic [7:0] c_GAP_LAST = 8'(GAP_CLKS - 1);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_START     = 3'd1;
   localparam logic [2:0] c_WAIT_LOW  = 3'd2;
   localparam logic [2:0] c_WAIT_HIGH = 3'd3;
   localparam logic [2:0] c_GAP       = 3'd4;

   logic [7:0]      r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [4:0]      r_level;
   logic            r_overflow;
   logic [2:0]      r_state;
   logic [7:0]      r_gap_cnt;
   logic            r_spi_start;
   logic [7:0]      r_spi_data;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_abort;

   assign w_full  = (r_level == c_DEPTH);
   assign w_empty = (r_level == 5'd0);
   assign w_push  = wr_en && !w_full;
   // The only pop is the IDLE->START hand-off of the FIFO head.
   assign w_pop   = (r_state == c_IDLE) && !w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= 5'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 5'd1;
            2'b01:   r_level <= r_level - 5'd1;
            default: r_level <= r_level;
         endcase
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef SPI_FEEDER_TIMEOUT_EN
   logic [9:0] r_to_cnt;
   logic       r_timeout;
   logic       w_stall;

   // Counts consecutive cycles spent waiting for the awaited spi_ss level.
   assign w_stall = ((r_state == c_WAIT_LOW) && spi_ss) ||
                    ((r_state == c_WAIT_HIGH) && !spi_ss);
   assign w_abort = w_stall && (r_to_cnt == 10'h3FF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt  <= 10'd0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_abort;
         r_to_cnt  <= w_stall ? (r_to_cnt + 10'd1) : 10'd0;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_gap_cnt   <= 8'd0;
         r_spi_start <= 1'b0;
         r_spi_data  <= 8'h00;
      end else begin
         r_spi_start <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_pop) begin
                  r_state     <= c_START;
                  r_spi_start <= 1'b1;
                  r_spi_data  <= r_mem[r_rd_ptr];
               end
            end
            c_START: begin
               r_state <= c_WAIT_LOW;
            end
            c_WAIT_LOW: begin
               if (!spi_ss) begin
                  r_state <= c_WAIT_HIGH;
               end else if (w_abort) begin
                  r_state <= c_IDLE;
               end
            end
            c_WAIT_HIGH: begin
               if (spi_ss) begin
                  r_state   <= c_GAP;
                  r_gap_cnt <= 8'd0;
               end else if (w_abort) begin
                  r_state <= c_IDLE;
               end
            end
            c_GAP: begin
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_state <= c_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign full      = w_full;
   assign empty     = w_empty;
   assign level     = r_level;
   assign overflow  = r_overflow;
   assign spi_start = r_spi_start;
   assign spi_data  = r_spi_data;
   assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_feeder
// Purpose  : Self-checking bench for spi_tx_feeder with a model SPI master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_feeder;

   localparam int DEPTH    = 8;
   localparam int GAP_CLKS = 4;

   typedef struct {
      logic [7:0] first;
      int         count;
      bit         lead;
      int         mlen;
      logic       exp_full;
      logic [4:0] exp_level;
      logic       exp_ovf;
   } vec_t;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       spi_ss  = 1'b1;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       spi_start;
   logic [7:0] spi_data;
   logic       busy;
   logic       overflow;
`ifdef SPI_FEEDER_TIMEOUT_EN
   logic       timeout;
`endif

   bit         master_en  = 1'b1;
   int         master_len = 5;

   int         n_vec     = 0;
   int         n_err     = 0;
   int         mon_vec   = 0;
   int         mon_err   = 0;
   int         start_cnt = 0;

   logic [7:0] m_q [$];
   int         m_level  = 0;
   bit         pend_acc = 1'b0;
   bit         pend_ovf = 1'b0;
   bit         m_ovf    = 1'b0;
   logic [7:0] m_data   = 8'h00;
   logic       prev_ss  = 1'b1;
   int         ss_since = 1000;

   always #5 clk = ~clk;

   spi_tx_feeder #(
      .DEPTH    (DEPTH),
      .GAP_CLKS (GAP_CLKS)
   ) dut (
      .clk       (clk),
      .reset     (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .spi_start (spi_start),
      .spi_data  (spi_data),
      .spi_ss    (spi_ss),
`ifdef SPI_FEEDER_TIMEOUT_EN
      .timeout   (timeout),
`endif
      .busy      (busy),
      .overflow  (overflow)
   );

   // Model master: pulls ss low two cycles after a request, holds it master_len cycles.
   always begin
      @(negedge clk);
      if (spi_start && master_en) begin
         repeat (2) @(posedge clk);
         #1 spi_ss = 1'b0;
         repeat (master_len) @(posedge clk);
         #1 spi_ss = 1'b1;
      end
   end

   // Scoreboard and occupancy model, evaluated mid-cycle.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      if (rst) begin
         m_q.delete();
         m_level  = 0;
         pend_acc = 1'b0;
         pend_ovf = 1'b0;
         m_ovf    = 1'b0;
         m_data   = 8'h00;
      end else begin
         if (spi_ss && !prev_ss) ss_since = 0;
         else if (ss_since < 100000) ss_since++;
         m_level = m_level + (pend_acc ? 1 : 0) - (spi_start ? 1 : 0);
         if (pend_ovf) m_ovf = 1'b1;
         if (spi_start) begin
            start_cnt++;
            mon_vec++;
            if (m_q.size() == 0) begin
               mon_err++;
               $display("FAIL unexpected_start: spi_data=%h with no byte queued", spi_data);
            end else begin
               exp_b  = m_q.pop_front();
               m_data = exp_b;
               if (!spi_ss || ss_since < GAP_CLKS + 2) begin
                  mon_err++;
                  $display("FAIL start_spacing: spi_ss=%b, %0d cycles since ss rise, required ss=1 and >= %0d",
                           spi_ss, ss_since, GAP_CLKS + 2);
               end
            end
         end
         mon_vec++;
         if (level !== 5'(m_level) || full !== (m_level == DEPTH) || empty !== (m_level == 0) ||
             overflow !== m_ovf || spi_data !== m_data) begin
            mon_err++;
            $display("FAIL status: level=%0d full=%b empty=%b ovf=%b data=%h, expected level=%0d full=%b empty=%b ovf=%b data=%h",
                     level, full, empty, overflow, spi_data,
                     m_level, (m_level == DEPTH), (m_level == 0), m_ovf, m_data);
         end
         pend_acc = wr_en && (m_level < DEPTH);
         pend_ovf = wr_en && (m_level >= DEPTH);
         if (pend_acc) m_q.push_back(wr_data);
      end
      prev_ss = spi_ss;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         if (empty && !busy && spi_ss && m_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, "_drained"}, 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      vec_t       vecs [6];
      int         n;
      int         starts_before;
      logic [7:0] b;

      vecs[0] = '{8'h5A, 1, 1'b0, 3,  1'b0, 5'd1, 1'b0};
      vecs[1] = '{8'h01, 8, 1'b1, 20, 1'b1, 5'd8, 1'b0};
      vecs[2] = '{8'h30, 9, 1'b0, 2,  1'b1, 5'd8, 1'b0};
      vecs[3] = '{8'h40, 3, 1'b0, 5,  1'b0, 5'd2, 1'b0};
      vecs[4] = '{8'hF7, 9, 1'b1, 20, 1'b1, 5'd8, 1'b1};
      vecs[5] = '{8'h50, 2, 1'b0, 1,  1'b0, 5'd1, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_level", level, 0);
      chk("rst_start", spi_start, 0);
      chk("rst_data", spi_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);

      // Single byte: request latency and gap timing with a long transfer.
      master_len    = 400;
      starts_before = start_cnt;
      push(8'hA5);
      chk("lat_no_start_yet", spi_start, 0);
      chk("lat_busy_idle", busy, 0);
      chk("lat_level", level, 1);
      @(posedge clk);
      #2;
      chk("lat_start", spi_start, 1);
      chk("lat_data", spi_data, 8'hA5);
      chk("lat_busy", busy, 1);
      n = 0;
      while (spi_ss && n < 50) begin @(posedge clk); #2; n++; end
      while (!spi_ss && n < 1000) begin @(posedge clk); #2; n++; end
      chk("a5_ss_cycle_seen", 32'(n < 1000), 1);
      chk("a5_busy_in_gap", busy, 1);
      n = 0;
      while (busy && n < 50) begin @(posedge clk); #2; n++; end
      chk("a5_busy_release", n, GAP_CLKS + 1);
      wait_drain("a5");
      chk("a5_one_start", start_cnt - starts_before, 1);

      for (int i = 0; i < 6; i++) begin
         master_len = vecs[i].mlen;
         if (vecs[i].lead) begin
            push(8'hC3);
            repeat (3) @(posedge clk);
            #1;
         end
         for (int j = 0; j < vecs[i].count; j++) begin
            b = vecs[i].first + 8'(j);
            push(b);
         end
         chk($sformatf("v%0d_full", i), full, vecs[i].exp_full);
         chk($sformatf("v%0d_level", i), level, vecs[i].exp_level);
         chk($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
         wait_drain($sformatf("v%0d", i));
      end

      // Reset while the master holds ss low with bytes queued.
      master_len = 20;
      push(8'hC3);
      n = 0;
      while (spi_ss && n < 20) begin @(posedge clk); #2; n++; end
      push(8'h61);
      push(8'h62);
      push(8'h63);
      chk("mid_level", level, 3);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #2;
      chk("mid_rst_full", full, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_start", spi_start, 0);
      chk("mid_rst_data", spi_data, 8'h00);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ovf", overflow, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      starts_before = start_cnt;
      repeat (60) @(posedge clk);
      #1;
      chk("mid_no_restart", start_cnt - starts_before, 0);
      chk("mid_still_idle", busy, 0);
      push(8'h77);
      wait_drain("post_rst");

`ifdef SPI_FEEDER_TIMEOUT_EN
      master_en = 1'b0;
      push(8'h91);
      push(8'h92);
      n = 1;
      for (int k = 0; k < 1200; k++) begin
         @(posedge clk);
         #2;
         n++;
         if (timeout) break;
      end
      chk("to_latency", n, 1026);
      chk("to_back_idle", busy, 0);
      @(posedge clk);
      #2;
      chk("to_pulse_width", timeout, 0);
      chk("to_next_start", spi_start, 1);
      chk("to_next_data", spi_data, 8'h92);
      wait_drain("timeout");
      master_en = 1'b1;
`endif

      n_vec += mon_vec;
      n_err += mon_err;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
